axi_rd_arbiter: RTL and testbench

- Shares one AXI3 read master port (AR + R channels) between NSRC independent burst readers, e.g. two frame-fetch sources feeding separate pixel pipes.
- Arbitrates the AR channel round-robin per burst, tags each burst's ARID with the requester index, and routes R beats back by RID.
- Bounds outstanding bursts per requester so one stalled consumer cannot monopolise the interconnect.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_rd_arbiter_rr_pick.sv | 28 ++
 rtl/axi_rd_arbiter.sv | 156 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 constants, the AXI state enum and the ARSIZE helper.
package axi_pkg;

    localparam int         IDW            = 6;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    // ARSIZE encoding for a data bus of the given width in bits.
    function automatic logic [2:0] axi_size(input int width);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == width) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NSRC = 2,
    parameter int PW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    int cand;

    // Scan from the far end back toward ptr so the closest request wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NSRC;
            if (req[cand]) begin
                any = 1'b1;
                idx = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read port between NSRC burst readers: round-robin AR,
// ARID = requester index, R beats routed back by RID, outstanding bursts bounded.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int NSRC    = 2,
    parameter int AXI     = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NSRC-1:0]     s_arvalid_i,
    input  logic [32*NSRC-1:0]  s_araddr_i,
    input  logic [4*NSRC-1:0]   s_arlen_i,
    output logic [NSRC-1:0]     s_arready_o,
    output logic [NSRC-1:0]     s_rvalid_o,
    input  logic [NSRC-1:0]     s_rready_i,
    output logic [AXI-1:0]      s_rdata_o,
    output logic                s_rlast_o,
    output logic                err_o,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [31:0]         m_axi_araddr,
    output logic [3:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic [1:0]          m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arqos,
    output logic [IDW-1:0]      m_axi_arid,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [AXI-1:0]      m_axi_rdata,
    input  logic                m_axi_rlast,
    input  logic [1:0]          m_axi_rresp,
    input  logic [IDW-1:0]      m_axi_rid
);

    localparam int PW = $clog2(NSRC);
    localparam int CW = $clog2(MAX_OUT + 1);

    arb_state_e      state, state_nxt;
    logic [PW-1:0]   grant, ptr, pick_idx;
    logic            pick_any;
    logic [CW-1:0]   out_cnt [NSRC];
    logic [NSRC-1:0] eligible, inc, dec;
    logic            ar_hs, r_hs, rid_ok, err_set;
    logic [PW-1:0]   rid_idx;

    // A requester may compete only while it has room for another burst.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            eligible[i] = s_arvalid_i[i] && (out_cnt[i] < CW'(MAX_OUT));
        end
    end

    rr_pick #(.NSRC(NSRC), .PW(PW)) u_pick (
        .req (eligible),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state and AR-side outputs; address/length follow the granted requester live.
    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        s_arready_o   = '0;
        case (state)
            ST_IDLE: if (pick_any) state_nxt = ST_HOLD;
            ST_HOLD: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    s_arready_o[grant] = 1'b1;
                    state_nxt          = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ar_hs         = (state == ST_HOLD) && m_axi_arready;
    assign m_axi_araddr  = s_araddr_i[32*grant +: 32];
    assign m_axi_arlen   = s_arlen_i[4*grant +: 4];
    assign m_axi_arid    = {{(IDW-PW){1'b0}}, grant};
    assign m_axi_arsize  = axi_size(AXI);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 2'b00;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;

    // Latch the winner and advance the pointer past it when leaving IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant <= '0;
            ptr   <= '0;
        end else if (state == ST_IDLE && pick_any) begin
            grant <= pick_idx;
            ptr   <= (pick_idx == PW'(NSRC - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // R routing: unknown RIDs are swallowed so the interconnect never stalls on them.
    assign rid_ok       = (m_axi_rid < IDW'(NSRC));
    assign rid_idx      = m_axi_rid[PW-1:0];
    assign m_axi_rready = rid_ok ? s_rready_i[rid_idx] : 1'b1;
    assign r_hs         = m_axi_rvalid && m_axi_rready;
    assign s_rdata_o    = m_axi_rdata;
    assign s_rlast_o    = m_axi_rlast;

    // Per-requester R valid and the counter increment/decrement strobes.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            s_rvalid_o[i] = m_axi_rvalid && (m_axi_rid == IDW'(i));
            inc[i]        = ar_hs && (grant == PW'(i));
            dec[i]        = r_hs && m_axi_rlast && (m_axi_rid == IDW'(i));
        end
    end

    // Error sources: bad response, unknown RID, or RLAST with nothing outstanding.
    always_comb begin
        err_set = r_hs && ((m_axi_rresp != AXI_RESP_OKAY) || !rid_ok);
        for (int i = 0; i < NSRC; i++) begin
            if (dec[i] && !inc[i] && out_cnt[i] == '0) err_set = 1'b1;
        end
    end

    // Outstanding burst counters; an underflowing decrement is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSRC; i++) out_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (inc[i] && !dec[i])
                    out_cnt[i] <= out_cnt[i] + 1'b1;
                else if (dec[i] && !inc[i] && out_cnt[i] != '0)
                    out_cnt[i] <= out_cnt[i] - 1'b1;
            end
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      err_o <= 1'b0;
        else if (err_set) err_o <= 1'b1;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised self-checking bench for axi_rd_arbiter (NSRC=2, AXI=64, MAX_OUT=4).
module tb_axi_rd_arbiter;

    localparam int NSRC    = 2;
    localparam int AXI     = 64;
    localparam int MAX_OUT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       s_arvalid;
    logic [63:0]      s_araddr;
    logic [7:0]       s_arlen;
    logic [1:0]       s_arready, s_rvalid, s_rready;
    logic [63:0]      s_rdata;
    logic             s_rlast, err;
    logic             m_arvalid, m_arready;
    logic [31:0]      m_araddr;
    logic [3:0]       m_arlen, m_arcache, m_arqos;
    logic [2:0]       m_arsize, m_arprot;
    logic [1:0]       m_arburst, m_arlock;
    logic [5:0]       m_arid;
    logic             m_rvalid, m_rready, m_rlast;
    logic [63:0]      m_rdata;
    logic [1:0]       m_rresp;
    logic [5:0]       m_rid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.NSRC(NSRC), .AXI(AXI), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_arvalid_i(s_arvalid), .s_araddr_i(s_araddr), .s_arlen_i(s_arlen),
        .s_arready_o(s_arready), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
        .s_rdata_o(s_rdata), .s_rlast_o(s_rlast), .err_o(err),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_araddr(m_araddr),
        .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
        .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
        .m_axi_arqos(m_arqos), .m_axi_arid(m_arid),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rdata(m_rdata),
        .m_axi_rlast(m_rlast), .m_axi_rresp(m_rresp), .m_axi_rid(m_rid)
    );

    task automatic idle_inputs();
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
        m_rresp = 2'b00; m_rid = '0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid got %b want 0", m_arvalid); end
        tests++; if (s_arready !== 2'b00) begin fails++; $display("FAIL reset_arready got %b want 00", s_arready); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        rst_n = 1'b1;
        tick(); #1;
        tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL post_reset_arvalid got %b want 0", m_arvalid); end
    endtask

    task automatic test_single();
        int pulses = 0;
        do_reset();
        m_arready = 1'b1;
        s_arvalid = 2'b01;
        s_araddr[31:0] = 32'h1000_0000;
        s_arlen[3:0] = 4'd15;
        #1;
        tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL single_latency got %b want 0", m_arvalid); end
        tick(); #1;
        tests++; if (m_arvalid !== 1'b1) begin fails++; $display("FAIL single_arvalid got %b want 1", m_arvalid); end
        tests++; if (m_araddr !== 32'h1000_0000) begin fails++; $display("FAIL single_araddr got %h want 10000000", m_araddr); end
        tests++; if (m_arlen !== 4'd15 || m_arid !== 6'd0) begin fails++; $display("FAIL single_len_id got %0d/%0d want 15/0", m_arlen, m_arid); end
        tests++; if (m_arsize !== 3'd3 || m_arburst !== 2'b01) begin fails++; $display("FAIL single_size_burst got %0d/%b want 3/01", m_arsize, m_arburst); end
        tests++; if ({m_arlock, m_arcache, m_arprot, m_arqos} !== 13'd0) begin fails++; $display("FAIL single_fixed_fields got nonzero want 0"); end
        if (s_arready[0]) pulses++;
        for (int c = 0; c < 4; c++) begin
            tick();
            s_arvalid = 2'b00;
            #1;
            if (s_arready !== 2'b00) pulses++;
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL single_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int ids[$];
        int last_c = -10;
        int gap_bad = 0;
        do_reset();
        m_arready = 1'b1;
        s_arvalid = 2'b11;
        s_araddr = {32'hB000_0100, 32'hA000_0200};
        s_arlen  = {4'd7, 4'd3};
        for (int c = 0; c < 24; c++) begin
            #1;
            if (m_arvalid && m_arready) begin
                ids.push_back(int'(m_arid));
                if (m_araddr !== s_araddr[32*m_arid[0] +: 32]) begin
                    tests++; fails++; $display("FAIL b2b_addr got %h id %0d", m_araddr, m_arid);
                end
                if (c - last_c != 2 && last_c >= 0) gap_bad++;
                last_c = c;
            end
            tick();
        end
        tests++; if (ids.size() != 2 * MAX_OUT) begin fails++; $display("FAIL b2b_count got %0d want %0d", ids.size(), 2 * MAX_OUT); end
        for (int k = 0; k < ids.size(); k++) begin
            tests++; if (ids[k] != k % 2) begin fails++; $display("FAIL b2b_order idx %0d got %0d want %0d", k, ids[k], k % 2); end
        end
        tests++; if (gap_bad != 0) begin fails++; $display("FAIL b2b_spacing got %0d bad gaps want 0", gap_bad); end
    endtask

    task automatic test_max_out();
        int hs = 0;
        bit found = 0;
        do_reset();
        m_arready = 1'b1;
        s_arvalid = 2'b01;
        s_araddr[31:0] = 32'h2000_0000;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_arvalid && m_arready) hs++;
            tick();
        end
        tests++; if (hs != MAX_OUT) begin fails++; $display("FAIL maxout_count got %0d want %0d", hs, MAX_OUT); end
        s_rready = 2'b01;
        for (int b = 0; b < 16; b++) begin
            m_rvalid = 1'b1; m_rid = 6'd0; m_rlast = (b == 15);
            m_rdata = {$urandom, $urandom};
            #1;
            if (s_rvalid !== 2'b01 || m_rready !== 1'b1 || s_rdata !== m_rdata) begin
                tests++; fails++; $display("FAIL maxout_rbeat %0d got v%b r%b want v01 r1", b, s_rvalid, m_rready);
            end
            if (m_arvalid && m_arready) hs++;
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            #1;
            if (m_arvalid && m_arready) begin hs++; found = 1; end
            tick();
        end
        tests++; if (hs != MAX_OUT + 1) begin fails++; $display("FAIL maxout_fifth got %0d want %0d", hs, MAX_OUT + 1); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL maxout_err got %b want 0", err); end
    endtask

    task automatic test_r_routing();
        logic [1:0] exp_v;
        do_reset();
        m_rvalid = 1'b1; m_rid = 6'd1; m_rlast = 1'b0; s_rready = 2'b01;
        m_rdata = 64'hDEAD_BEEF_0123_4567;
        #1;
        tests++; if (m_rready !== 1'b0) begin fails++; $display("FAIL route_stall got %b want 0", m_rready); end
        tick();
        s_rready = 2'b11;
        #1;
        tests++; if (m_rready !== 1'b1 || s_rvalid !== 2'b10) begin fails++; $display("FAIL route_go got r%b v%b want r1 v10", m_rready, s_rvalid); end
        tests++; if (s_rdata !== 64'hDEAD_BEEF_0123_4567) begin fails++; $display("FAIL route_data got %h want deadbeef01234567", s_rdata); end
        for (int b = 0; b < 16; b++) begin
            tick();
            m_rid = 6'($urandom_range(0, 1));
            s_rready = 2'($urandom);
            m_rvalid = 1'($urandom);
            m_rdata = {$urandom, $urandom};
            #1;
            exp_v = m_rvalid ? (2'b01 << m_rid) : 2'b00;
            tests++;
            if (s_rvalid !== exp_v || m_rready !== s_rready[m_rid] || s_rdata !== m_rdata || s_rlast !== m_rlast) begin
                fails++; $display("FAIL route_rand %0d got v%b r%b want v%b r%b", b, s_rvalid, m_rready, exp_v, s_rready[m_rid]);
            end
        end
        tick();
        m_rvalid = 1'b0;
        #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL route_err got %b want 0", err); end
    endtask

    task automatic test_errors();
        // Unknown RID: accepted and dropped.
        do_reset();
        m_rvalid = 1'b1; m_rid = 6'd5; s_rready = 2'b00;
        #1;
        tests++; if (m_rready !== 1'b1 || s_rvalid !== 2'b00) begin fails++; $display("FAIL badrid_drop got r%b v%b want r1 v00", m_rready, s_rvalid); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL badrid_early got %b want 0", err); end
        tick();
        m_rvalid = 1'b0;
        #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL badrid_err got %b want 1", err); end
        repeat (3) tick();
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
        do_reset();
        #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_cleared got %b want 0", err); end
        // Bad response without a handshake must not flag.
        m_rvalid = 1'b1; m_rid = 6'd0; m_rresp = 2'b10; s_rready = 2'b00;
        tick();
        #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL slverr_nohs got %b want 0", err); end
        s_rready = 2'b01;
        tick();
        m_rvalid = 1'b0; m_rresp = 2'b00;
        #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL slverr got %b want 1", err); end
        // RLAST with no outstanding burst.
        do_reset();
        m_rvalid = 1'b1; m_rid = 6'd1; m_rlast = 1'b1; s_rready = 2'b10;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL underflow got %b want 1", err); end
    endtask

    task automatic test_random_ar();
        int mcnt[NSRC];
        int mptr = 0;
        int pend = 0;
        int acc;
        bit exp_av = 0;
        logic [1:0] elig;
        do_reset();
        for (int i = 0; i < NSRC; i++) mcnt[i] = 0;
        for (int c = 0; c < 80; c++) begin
            acc = -1;
            for (int i = 0; i < NSRC; i++) begin
                if (!s_arvalid[i] && $urandom_range(0, 2) == 0) begin
                    s_arvalid[i] = 1'b1;
                    s_araddr[32*i +: 32] = $urandom;
                    s_arlen[4*i +: 4] = 4'($urandom);
                end
            end
            m_arready = 1'($urandom);
            #1;
            tests++; if (m_arvalid !== exp_av) begin fails++; $display("FAIL rand_arvalid cyc %0d got %b want %b", c, m_arvalid, exp_av); end
            if (exp_av) begin
                tests++;
                if (m_arid !== 6'(pend) || m_araddr !== s_araddr[32*pend +: 32] || m_arlen !== s_arlen[4*pend +: 4]) begin
                    fails++; $display("FAIL rand_ar cyc %0d got id%0d %h want id%0d %h", c, m_arid, m_araddr, pend, s_araddr[32*pend +: 32]);
                end
                tests++;
                if (s_arready !== (m_arready ? 2'(1 << pend) : 2'b00)) begin
                    fails++; $display("FAIL rand_arready cyc %0d got %b", c, s_arready);
                end
                if (m_arready) begin
                    mcnt[pend]++;
                    acc = pend;
                    exp_av = 0;
                end
            end else begin
                tests++; if (s_arready !== 2'b00) begin fails++; $display("FAIL rand_idle_arready cyc %0d got %b want 00", c, s_arready); end
                for (int i = 0; i < NSRC; i++) elig[i] = s_arvalid[i] && (mcnt[i] < MAX_OUT);
                for (int k = 0; k < NSRC && !exp_av; k++) begin
                    if (elig[(mptr + k) % NSRC]) begin
                        pend = (mptr + k) % NSRC;
                        mptr = (pend + 1) % NSRC;
                        exp_av = 1;
                    end
                end
            end
            tick();
            if (acc >= 0) s_arvalid[acc] = 1'b0;
        end
    endtask

    task automatic test_reset_in_hold();
        bit found = 0;
        do_reset();
        s_arvalid = 2'b01; m_arready = 1'b1;
        tick();
        tick();
        s_arvalid = 2'b00; m_arready = 1'b0;
        tick();
        s_arvalid = 2'b01;
        for (int c = 0; c < 5 && !found; c++) begin
            tick();
            #1;
            if (m_arvalid) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL hold_wait got no arvalid want 1"); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (m_arvalid !== 1'b0 || s_arready !== 2'b00) begin fails++; $display("FAIL async_reset got av%b ar%b want 0 00", m_arvalid, s_arready); end
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Counter for requester 0 must have been cleared: this RLAST underflows.
        m_rvalid = 1'b1; m_rid = 6'd0; m_rlast = 1'b1; s_rready = 2'b01;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL cnt_cleared got err %b want 1", err); end
        s_arvalid = 2'b11; m_arready = 1'b1;
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            #1;
            if (m_arvalid) begin
                found = 1;
                tests++; if (m_arid !== 6'd0) begin fails++; $display("FAIL ptr_reset got id %0d want 0", m_arid); end
            end
            tick();
        end
        if (!found) begin tests++; fails++; $display("FAIL ptr_reset_wait got no arvalid want 1"); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_max_out();
        test_r_routing();
        test_errors();
        test_random_ar();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
